inter_ram_wait: RTL and testbench
=================================

Name: inter_ram_wait

Overview:
- Parametrised on-chip bus RAM slave; the next generation of the single-cycle internal RAM.
- Generalises data width, depth and wait states, and adds byte-lane writes, out-of-range error signalling and an explicit access FSM.
- Sits on the system bus behind the address decoder, which drives cs_i; memory is a behavioural inferred synchronous RAM, not a vendor macro.

Parameters:
DATA_W, 32, data bus width in bits; multiple of 8, at least 8
DEPTH, 16384, number of DATA_W-bit words; need not be a power of two
WAIT_STATES, 0, extra cycles inserted between access acceptance and ack/err (0..15)

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_i  in  1  reset, asynchronous, active-high
cs_i  in  1  chip select/request; held high by the master until ack_o or err_o
we_i  in  1  1 = write, 0 = read
sel_i  in  DATA_W/8  byte-lane enables for writes; bit k enables dat_i[8k+7:8k]
adr_i  in  32  byte address; word index = adr_i >> log2(DATA_W/8), low bits ignored
dat_i  in  DATA_W  write data
dat_o  out  DATA_W  read data; valid only in the ack_o cycle
ack_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle error pulse for an out-of-range word index
busy_o  out  1  high while the init-clear sequence runs; tied 0 without the optional feature

Behaviour:
- Reset (async assert): state=IDLE; ack_o=0, err_o=0, dat_o=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP (plus CLEAR with the optional feature).
- IDLE, cs_i=1: accept the access at this edge and latch we_i, sel_i, word index and dat_i.
  - In-range write: RAM words are updated at the acceptance edge, enabled lanes only; other lanes keep their value.
  - In-range read: RAM read at the acceptance edge; the result is held in a register until the response.
  - Then go to WAIT if WAIT_STATES>0, else RESP.
- WAIT: counter counts 1..WAIT_STATES; go to RESP when the count reaches WAIT_STATES. cs_i and inputs are ignored.
- RESP cycle: exactly one of ack_o or err_o is high for exactly one cycle, then return to IDLE.
  - Read ack: dat_o = latched read data.
  - Write ack: dat_o = 0.
- Latency: acceptance edge N; response high in cycle after edge N+1+WAIT_STATES. With WAIT_STATES=0 this is the legacy 1-cycle ack.
- Back-to-back: the master drops cs_i after sampling ack. If cs_i is still high in IDLE, a new access is accepted, giving one access per 2+WAIT_STATES cycles.
- Out of range (word index >= DEPTH):
  - No RAM write and no RAM read.
  - err_o pulses in place of ack_o with identical timing; dat_o=0.
- Width rules:
  - The word index uses the address bits above the byte-offset bits, zero-extended for the compare against DEPTH.
  - sel_i=0 on a write still acks and changes nothing.
- Reset mid-access: the FSM returns to IDLE immediately and no response is issued. A write already committed at its acceptance edge remains in the RAM.
- cs_i low in IDLE: outputs stay 0 and the RAM is untouched.

Optional Feature:
Macro INTER_RAM_CLEAR_EN.
- Defined:
  - After rst_i deasserts, the FSM enters CLEAR, writes 0 to word 0..DEPTH-1 (one word per cycle, ascending), with busy_o=1.
  - Takes DEPTH cycles, then goes to IDLE with busy_o=0.
  - cs_i is not accepted during CLEAR; a held request is accepted on the first IDLE edge.
  - Reset during CLEAR restarts clearing from word 0.
- Undefined: no CLEAR state; busy_o constant 0; RAM power-up contents undefined.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to adr 0x10 with sel=0xF, then read 0x10 -> each ack 1 cycle after acceptance; read dat_o=0xDEADBEEF in the ack cycle.
- Byte lanes: preload 0x11223344 at adr 0x20, then write 0xAABBCCDD with sel=0x5 -> read returns 0x11BB33DD.
- WAIT_STATES=3: read request -> ack exactly 4 cycles after the acceptance edge; ack and err low in between.
- DEPTH=1000: access adr 1000*4=0xFA0 -> err_o 1 cycle, ack_o=0, dat_o=0. Then read adr 0xF9C (word 999) -> normal ack.
- Assert rst_i in the WAIT state of a write with WAIT_STATES=2 -> no ack/err pulse. A later read returns the written data.
- INTER_RAM_CLEAR_EN, DEPTH=16: cs_i high immediately after reset -> busy_o high 16 cycles, then ack. A read of any word returns 0.

Source files
------------

// File: rtl/inter_ram_wait.sv
// inter_ram_wait: bus RAM slave with byte-lane writes, programmable wait states and out-of-range error.
// Response 1+WAIT_STATES cycles after acceptance; optional power-up clear under INTER_RAM_CLEAR_EN.
module inter_ram_wait #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16384,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cs_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] sel_i,
    input  logic [31:0]         adr_i,
    input  logic [DATA_W-1:0]   dat_i,
    output logic [DATA_W-1:0]   dat_o,
    output logic                ack_o,
    output logic                err_o,
    output logic                busy_o
);
    localparam int NB  = DATA_W / 8;
    localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
`ifdef INTER_RAM_CLEAR_EN
        , S_CLEAR
`endif
    } state_t;

`ifdef INTER_RAM_CLEAR_EN
    localparam state_t RST_STATE = S_CLEAR;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_nxt;
    logic              we_q;
    logic              oor_q;
    logic [DATA_W-1:0] rd_q;
    logic [31:0]       word_idx;
    logic              in_range;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [NB-1:0]     wr_lane;
    logic [AW-1:0]     wr_adr;
    logic [DATA_W-1:0] wr_dat;
    logic              rd_en;

`ifdef INTER_RAM_CLEAR_EN
    logic [AW-1:0]     clr_adr;
`endif

    assign word_idx = adr_i >> OFF;
    assign in_range = word_idx < 32'(DEPTH);
    assign wait_nxt = wait_cnt + 4'd1;

    // RAM port: accesses commit at the acceptance edge; the clear sweep owns the port while busy.
    always_comb begin
        wr_lane = '0;
        wr_adr  = word_idx[AW-1:0];
        wr_dat  = dat_i;
        rd_en   = 1'b0;
        if (!rst_i && state == S_IDLE && cs_i && in_range) begin
            if (we_i) wr_lane = sel_i;
            else      rd_en   = 1'b1;
        end
`ifdef INTER_RAM_CLEAR_EN
        if (!rst_i && state == S_CLEAR) begin
            wr_lane = '1;
            wr_adr  = clr_adr;
            wr_dat  = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NB; k++) begin
            if (wr_lane[k]) mem[wr_adr][k*8 +: 8] <= wr_dat[k*8 +: 8];
        end
        if (rd_en) rd_q <= mem[wr_adr];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= RST_STATE;
            wait_cnt <= 4'd0;
            we_q     <= 1'b0;
            oor_q    <= 1'b0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            dat_o    <= '0;
`ifdef INTER_RAM_CLEAR_EN
            clr_adr  <= '0;
`endif
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
            case (state)
                S_IDLE: begin
                    if (cs_i) begin
                        we_q     <= we_i;
                        oor_q    <= !in_range;
                        wait_cnt <= 4'd0;
                        state    <= (WS != 4'd0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_nxt;
                    if (wait_nxt == WS) state <= S_RESP;
                end
                S_RESP: begin
                    if (oor_q) begin
                        err_o <= 1'b1;
                    end else begin
                        ack_o <= 1'b1;
                        dat_o <= we_q ? '0 : rd_q;
                    end
                    state <= S_IDLE;
                end
`ifdef INTER_RAM_CLEAR_EN
                S_CLEAR: begin
                    clr_adr <= clr_adr + AW'(1);
                    if (clr_adr == AW'(DEPTH - 1)) state <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef INTER_RAM_CLEAR_EN
    assign busy_o = (state == S_CLEAR);
`else
    assign busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_inter_ram_wait.sv
// Bench for inter_ram_wait: three instances (0, 3 and 2 wait states, DEPTH=1000) against a byte-level memory model.
module tb_inter_ram_wait;
    localparam int DEPTH = 1000;
    localparam int NI    = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NI-1:0]   cs  = '0;
    logic            we  = 1'b0;
    logic [3:0]      sel = 4'h0;
    logic [31:0]     adr = '0;
    logic [31:0]     dat = '0;
    logic [31:0]     dato [NI];
    logic [NI-1:0]   ack;
    logic [NI-1:0]   err;
    logic [NI-1:0]   busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [NI][DEPTH];
    bit   [3:0]  mbv [NI][DEPTH];

    always #5 clk = ~clk;

    inter_ram_wait #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_i(rst), .cs_i(cs[0]), .we_i(we), .sel_i(sel), .adr_i(adr),
        .dat_i(dat), .dat_o(dato[0]), .ack_o(ack[0]), .err_o(err[0]), .busy_o(busy[0]));
    inter_ram_wait #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .clk_i(clk), .rst_i(rst), .cs_i(cs[1]), .we_i(we), .sel_i(sel), .adr_i(adr),
        .dat_i(dat), .dat_o(dato[1]), .ack_o(ack[1]), .err_o(err[1]), .busy_o(busy[1]));
    inter_ram_wait #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .clk_i(clk), .rst_i(rst), .cs_i(cs[2]), .we_i(we), .sel_i(sel), .adr_i(adr),
        .dat_i(dat), .dat_o(dato[2]), .ack_o(ack[2]), .err_o(err[2]), .busy_o(busy[2]));

    function automatic int ws_of(input int i);
        if (i == 1) return 3;
        if (i == 2) return 2;
        return 0;
    endfunction

    // Reference memory: per-byte known flags; a reset with power-up clear makes every word a known zero.
    task automatic model_reset();
`ifdef INTER_RAM_CLEAR_EN
        for (int i = 0; i < NI; i++)
            for (int w = 0; w < DEPTH; w++) begin
                mdl[i][w] = '0;
                mbv[i][w] = 4'hF;
            end
`endif
    endtask

    task automatic model_acc(input int i, input logic w, input logic [3:0] s, input logic [31:0] a,
                             input logic [31:0] d, output logic e_err, output logic e_known,
                             output logic [31:0] e_dat);
        int unsigned wi;
        wi      = a >> 2;
        e_err   = (wi >= 32'(DEPTH));
        e_known = 1'b1;
        e_dat   = '0;
        if (!e_err) begin
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (s[k]) begin
                        mdl[i][wi][k*8 +: 8] = d[k*8 +: 8];
                        mbv[i][wi][k] = 1'b1;
                    end
            end else begin
                e_known = (mbv[i][wi] == 4'hF);
                e_dat   = mdl[i][wi];
            end
        end
    endtask

    // Master driver: raises cs, waits for the response, drops cs in the response cycle.
    task automatic do_acc(input int i, input logic w, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic g_ack, output logic g_err,
                          output logic [31:0] rdat, output logic quiet);
        @(negedge clk);
        we = w; sel = s; adr = a; dat = d; cs[i] = 1'b1;
        lat = -1; g_ack = 1'b0; g_err = 1'b0; rdat = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ack[i] || err[i]) begin
                lat = n - 1; g_ack = ack[i]; g_err = err[i]; rdat = dato[i];
                break;
            end
        end
        cs[i] = 1'b0;
        @(posedge clk); #1;
        quiet = !ack[i] && !err[i];
    endtask

    task automatic wait_busy_low(output int cyc);
        cyc = 0;
        #1;
        while (busy != '0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1; cs = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (ack[i] !== 1'b0 || err[i] !== 1'b0 || dato[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs inst %0d ack=%b err=%b dat=%h want 0/0/0", i, ack[i], err[i], dato[i]);
            end
        end
`ifndef INTER_RAM_CLEAR_EN
        checks++;
        if (busy !== 3'b000) begin
            errors++;
            $display("FAIL reset_busy got %b want 000", busy);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_busy_low(cyc);
        checks++;
`ifdef INTER_RAM_CLEAR_EN
        if (cyc != DEPTH) begin
            errors++;
            $display("FAIL clear_busy_cycles got %0d want %0d", cyc, DEPTH);
        end
`else
        if (cyc != 0) begin
            errors++;
            $display("FAIL busy_tied_low got %0d busy cycles want 0", cyc);
        end
`endif
    endtask

    task automatic test_basic();
        int lat; logic ga, ge, q, ee, ek; logic [31:0] rd, ed;
        model_acc(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, ee, ek, ed);
        do_acc(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, ga, ge, rd, q);
        checks++;
        if (lat != 1 || ga !== 1'b1 || ge !== 1'b0 || rd !== 32'h0 || q !== 1'b1) begin
            errors++;
            $display("FAIL basic_write lat=%0d ack=%b err=%b dat=%h quiet=%b want 1/1/0/0/1", lat, ga, ge, rd, q);
        end
        model_acc(0, 1'b0, 4'h0, 32'h10, 32'h0, ee, ek, ed);
        do_acc(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, ga, ge, rd, q);
        checks++;
        if (lat != 1 || ga !== 1'b1 || rd !== 32'hDEADBEEF || q !== 1'b1) begin
            errors++;
            $display("FAIL basic_read lat=%0d ack=%b dat=%h quiet=%b want 1/1/deadbeef/1", lat, ga, rd, q);
        end
    endtask

    task automatic test_byte_lanes();
        int lat; logic ga, ge, q, ee, ek; logic [31:0] rd, ed;
        model_acc(0, 1'b1, 4'hF, 32'h20, 32'h11223344, ee, ek, ed);
        do_acc(0, 1'b1, 4'hF, 32'h20, 32'h11223344, lat, ga, ge, rd, q);
        model_acc(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD, ee, ek, ed);
        do_acc(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD, lat, ga, ge, rd, q);
        model_acc(0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, ee, ek, ed);
        do_acc(0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, lat, ga, ge, rd, q);
        checks++;
        if (ga !== 1'b1 || ge !== 1'b0) begin
            errors++;
            $display("FAIL sel_zero_ack ack=%b err=%b want 1/0", ga, ge);
        end
        do_acc(0, 1'b0, 4'h0, 32'h20, 32'h0, lat, ga, ge, rd, q);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_lanes got %h want 11bb33dd", rd);
        end
    endtask

    task automatic test_wait3();
        int lat; logic ga, ge, q, ee, ek; logic [31:0] rd, ed;
        model_acc(1, 1'b1, 4'hF, 32'h44, 32'hCAFEF00D, ee, ek, ed);
        do_acc(1, 1'b1, 4'hF, 32'h44, 32'hCAFEF00D, lat, ga, ge, rd, q);
        checks++;
        if (lat != 4 || ga !== 1'b1) begin
            errors++;
            $display("FAIL wait3_write lat=%0d ack=%b want 4/1", lat, ga);
        end
        do_acc(1, 1'b0, 4'h0, 32'h44, 32'h0, lat, ga, ge, rd, q);
        checks++;
        if (lat != 4 || ga !== 1'b1 || rd !== 32'hCAFEF00D || q !== 1'b1) begin
            errors++;
            $display("FAIL wait3_read lat=%0d ack=%b dat=%h quiet=%b want 4/1/cafef00d/1", lat, ga, rd, q);
        end
    endtask

    task automatic test_range(input int i);
        int lat; logic ga, ge, q, ee, ek; logic [31:0] rd, ed;
        do_acc(i, 1'b1, 4'hF, 32'hFA0, 32'h12345678, lat, ga, ge, rd, q);
        checks++;
        if (lat != 1 + ws_of(i) || ga !== 1'b0 || ge !== 1'b1 || rd !== 32'h0 || q !== 1'b1) begin
            errors++;
            $display("FAIL range_err_wr inst %0d lat=%0d ack=%b err=%b dat=%h want %0d/0/1/0", i, lat, ga, ge, rd, 1 + ws_of(i));
        end
        do_acc(i, 1'b0, 4'h0, 32'hFA0, 32'h0, lat, ga, ge, rd, q);
        checks++;
        if (ga !== 1'b0 || ge !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL range_err_rd inst %0d ack=%b err=%b dat=%h want 0/1/0", i, ga, ge, rd);
        end
        model_acc(i, 1'b1, 4'hF, 32'hF9C, 32'h0BADF00D, ee, ek, ed);
        do_acc(i, 1'b1, 4'hF, 32'hF9C, 32'h0BADF00D, lat, ga, ge, rd, q);
        do_acc(i, 1'b0, 4'h0, 32'hF9C, 32'h0, lat, ga, ge, rd, q);
        checks++;
        if (ga !== 1'b1 || ge !== 1'b0 || rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL range_last_word inst %0d ack=%b err=%b dat=%h want 1/0/0badf00d", i, ga, ge, rd);
        end
    endtask

    task automatic test_back_to_back(input int i);
        int lat, last, seen; logic ga, ge, q, ee, ek; logic [31:0] rd, ed, d;
        d = $urandom;
        model_acc(i, 1'b1, 4'hF, 32'h40, d, ee, ek, ed);
        do_acc(i, 1'b1, 4'hF, 32'h40, d, lat, ga, ge, rd, q);
        last = 0; seen = 0;
        @(negedge clk);
        we = 1'b0; sel = 4'h0; adr = 32'h40; cs[i] = 1'b1;
        for (int n = 1; n <= 60 && seen < 3; n++) begin
            @(posedge clk); #1;
            if (ack[i] || err[i]) begin
                checks++;
                if (dato[i] !== d || (seen > 0 && n - last != 2 + ws_of(i)) || (seen == 0 && n - 1 != 1 + ws_of(i))) begin
                    errors++;
                    $display("FAIL b2b inst %0d resp %0d at cycle %0d prev %0d dat=%h want %h", i, seen, n, last, dato[i], d);
                end
                last = n;
                seen++;
                if (seen == 3) cs[i] = 1'b0;
            end
        end
        cs[i] = 1'b0;
        checks++;
        if (seen != 3) begin
            errors++;
            $display("FAIL b2b_count inst %0d got %0d want 3", i, seen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, hits, cyc; logic ga, ge, q, ee, ek; logic [31:0] rd, ed, d;
        d = $urandom;
        @(negedge clk);
        we = 1'b1; sel = 4'hF; adr = 32'h30; dat = d; cs[2] = 1'b1;
        @(posedge clk); #1;
        cs[2] = 1'b0;
        model_acc(2, 1'b1, 4'hF, 32'h30, d, ee, ek, ed);
        @(posedge clk); #1;
        rst = 1'b1;
        hits = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (8) begin
            @(posedge clk); #1;
            if (ack[2] || err[2]) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL reset_mid_no_resp got %0d pulses want 0", hits);
        end
        wait_busy_low(cyc);
        model_acc(2, 1'b0, 4'h0, 32'h30, 32'h0, ee, ek, ed);
        do_acc(2, 1'b0, 4'h0, 32'h30, 32'h0, lat, ga, ge, rd, q);
        checks++;
        if (ga !== 1'b1 || rd !== ed) begin
            errors++;
            $display("FAIL reset_mid_readback ack=%b dat=%h want 1/%h", ga, rd, ed);
        end
    endtask

    task automatic test_random(input int i);
        int lat, r, w; logic ga, ge, q, ee, ek, wr; logic [3:0] s; logic [31:0] rd, ed, a, d;
        for (int t = 0; t < 25; t++) begin
            r  = $urandom_range(0, 11);
            w  = (r < 8) ? r : 990 + r;
            a  = 32'(w * 4 + $urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            s  = 4'($urandom_range(0, 15));
            d  = $urandom;
            model_acc(i, wr, s, a, d, ee, ek, ed);
            do_acc(i, wr, s, a, d, lat, ga, ge, rd, q);
            checks++;
            if (lat != 1 + ws_of(i) || ga !== !ee || ge !== ee || q !== 1'b1 || (ek && rd !== ed)) begin
                errors++;
                $display("FAIL random inst %0d adr=%h we=%b lat=%0d ack=%b err=%b dat=%h want lat %0d err %b dat %h",
                         i, a, wr, lat, ga, ge, rd, 1 + ws_of(i), ee, ek ? ed : rd);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_wait3();
        test_range(0);
        test_range(1);
        test_back_to_back(0);
        test_back_to_back(1);
        test_reset_mid();
        for (int i = 0; i < NI; i++) test_random(i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
